// File: rtl/kmeans_pkg.sv
// Shared definitions for the k-means sequencer: data widths, per-core control bit
// positions and the sequencer state encoding.
package kmeans_pkg;

  localparam int PIX_W  = 24;
  localparam int DIST_W = 10;

  // Per-core control field, packed as {enable,compareOnly,isClosest,updateMean,allMeansStable}
  localparam int CTRL_W         = 5;
  localparam int CTRL_ALLSTABLE = 0;
  localparam int CTRL_UPDATE    = 1;
  localparam int CTRL_CLOSEST   = 2;
  localparam int CTRL_CMPONLY   = 3;
  localparam int CTRL_EN        = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_COMPARE,
    S_ACCUM,
    S_UPDATE,
    S_CHECK,
    S_DONE
  } seq_state_e;

  // Keeps the address bus at least one bit wide for single-pixel frames.
  function automatic int addr_width(input int npix);
    return (npix > 1) ? $clog2(npix) : 1;
  endfunction

endpackage

// File: rtl/kmeans_argmin.sv
// Combinational argmin over K unsigned distances; the lowest index wins on ties.
module kmeans_argmin #(
  parameter int K      = 4,
  parameter int DIST_W = 10,
  parameter int IDX_W  = $clog2(K)
) (
  input  logic [K*DIST_W-1:0] distance,
  output logic [IDX_W-1:0]    index
);

  logic [DIST_W-1:0] best;

  always_comb begin
    best  = distance[0 +: DIST_W];
    index = '0;
    // Strict less-than keeps the earlier (lower) index when distances are equal.
    for (int i = 1; i < K; i++) begin
      if (distance[i*DIST_W +: DIST_W] < best) begin
        best  = distance[i*DIST_W +: DIST_W];
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/kmeans_sequencer.sv
// Streams a frame to K k-means cores, labels each pixel with the nearest core and
// iterates mean updates until every core reports stable or the pass limit is reached.
module kmeans_sequencer #(
  parameter int  K        = 4,
  parameter int  PIX_W    = kmeans_pkg::PIX_W,
  parameter int  DIST_W   = kmeans_pkg::DIST_W,
  parameter int  NPIX     = 4096,
  parameter int  MAX_ITER = 16,
  localparam int AW       = kmeans_pkg::addr_width(NPIX),
  localparam int IW       = $clog2(MAX_ITER + 1),
  localparam int LW       = $clog2(K),
  localparam int CW       = kmeans_pkg::CTRL_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [AW-1:0]       pixel_addr,
  input  logic [PIX_W-1:0]    pixel_rdata,
  output logic [PIX_W-1:0]    pixelOut,
  input  logic [K*DIST_W-1:0] core_distance,
  input  logic [K-1:0]        core_busy,
  input  logic [K-1:0]        core_stable,
  output logic [K*CW-1:0]     core_control,
  output logic [LW-1:0]       label_out,
  output logic                label_valid,
  output logic                label_final,
  output logic [IW-1:0]       iter_count,
  output logic                busy,
  output logic                done
);

  import kmeans_pkg::*;

  seq_state_e       state, state_nxt;
  logic [AW-1:0]    addr;
  logic [IW-1:0]    iter;
  logic [IW-1:0]    iter_inc;
  logic [K-1:0]     stable_q;
  logic [PIX_W-1:0] pix_q;
  logic [LW-1:0]    winner;
  logic             last_pix;
  logic             finish_now;

  kmeans_argmin #(
    .K      (K),
    .DIST_W (DIST_W),
    .IDX_W  (LW)
  ) u_argmin (
    .distance (core_distance),
    .index    (winner)
  );

  assign last_pix   = (addr == AW'(NPIX - 1));
  assign iter_inc   = (iter == IW'(MAX_ITER)) ? iter : iter + 1'b1;
  assign finish_now = (&stable_q) || (iter_inc == IW'(MAX_ITER));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      addr     <= '0;
      iter     <= '0;
      stable_q <= '0;
      pix_q    <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE: if (start) begin
          addr     <= '0;
          iter     <= '0;
          stable_q <= '0;
        end
        S_ISSUE:  pix_q <= pixel_rdata;
        S_ACCUM:  if (!last_pix) addr <= addr + 1'b1;
        S_UPDATE: if (!(|core_busy)) stable_q <= core_stable;
        S_CHECK: begin
          iter <= iter_inc;
          addr <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_nxt    = state;
    core_control = '0;
    label_out    = '0;
    label_valid  = 1'b0;
    label_final  = 1'b0;
    busy         = (state != S_IDLE);
    done         = 1'b0;

    unique case (state)
      S_IDLE:    if (start) state_nxt = S_FETCH;
      S_FETCH:   state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = S_COMPARE;
      S_COMPARE: begin
        state_nxt   = S_ACCUM;
        label_out   = winner;
        label_valid = 1'b1;
        label_final = (iter == IW'(MAX_ITER - 1));
      end
      S_ACCUM:   state_nxt = last_pix ? S_UPDATE : S_FETCH;
      S_UPDATE:  if (!(|core_busy)) state_nxt = S_CHECK;
      S_CHECK:   state_nxt = finish_now ? S_DONE : S_FETCH;
      S_DONE: begin
        state_nxt = S_IDLE;
        done      = 1'b1;
      end
      default:   state_nxt = S_IDLE;
    endcase

    for (int i = 0; i < K; i++) begin
      core_control[i*CW + CTRL_EN]        = busy;
      core_control[i*CW + CTRL_CMPONLY]   = 1'b0;
      core_control[i*CW + CTRL_CLOSEST]   = (state == S_COMPARE) && (winner == LW'(i));
      core_control[i*CW + CTRL_UPDATE]    = (state == S_COMPARE) && last_pix;
      core_control[i*CW + CTRL_ALLSTABLE] = (state == S_DONE);
    end
  end

  assign pixel_addr = addr;
  assign pixelOut   = pix_q;
  assign iter_count = iter;

endmodule
